// File: rtl/pe_no_fifo_if.sv
// Operand/result bundle for the pe_no_fifo multiply-accumulate element.
// The master drives framed operand pairs and the slave returns the accumulator.
interface pe_no_fifo_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = DATA_WIDTH ** 2
);
  logic                  start;
  logic                  valid_in;
  logic                  last;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [ACC_WIDTH-1:0]  c;
  logic                  output_valid;

  modport master (output start, valid_in, last, a, b, input c, output_valid);
  modport slave  (input start, valid_in, last, a, b, output c, output_valid);
endinterface

// File: rtl/pe_no_fifo.sv
// Three-stage unsigned MAC: S1 input register, S2 product register, S3 accumulator.
// Optional macro PE_SATURATE_EN clamps the accumulator at its maximum instead of wrapping.
module pe_no_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = DATA_WIDTH ** 2
) (
  input  logic         clk,
  input  logic         clr,
  pe_no_fifo_if.slave  bus
);
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] s1_a, s1_b;
  logic                  s1_valid, s1_start, s1_last;
  logic [PROD_WIDTH-1:0] s2_prod;
  logic                  s2_valid, s2_start, s2_last;
  logic [ACC_WIDTH-1:0]  acc;
  logic                  acc_done;
  logic [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH:0]    sum_full;
  logic [ACC_WIDTH-1:0]  acc_add;

  // NOTE: clocked state uses non-blocking (<=) so every stage samples the pre-edge values of the stage before it.
  always_ff @(posedge clk) begin
    if (clr) begin
      s1_a     <= '0;
      s1_b     <= '0;
      s1_valid <= 1'b0;
      s1_start <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_a     <= bus.a;
      s1_b     <= bus.b;
      s1_valid <= bus.valid_in;
      s1_start <= bus.start;
      s1_last  <= bus.last;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      s2_prod  <= '0;
      s2_valid <= 1'b0;
      s2_start <= 1'b0;
      s2_last  <= 1'b0;
    end else begin
      s2_prod  <= PROD_WIDTH'(s1_a) * PROD_WIDTH'(s1_b);
      s2_valid <= s1_valid;
      s2_start <= s1_start;
      s2_last  <= s1_last;
    end
  end

  // Product is zero-extended or truncated to the accumulator width.
  always_comb begin
    prod_ext = ACC_WIDTH'(s2_prod);
    sum_full = {1'b0, acc} + {1'b0, prod_ext};
`ifdef PE_SATURATE_EN
    // A clamped acc stays at all-ones for every later add, so saturation is sticky until start.
    acc_add = sum_full[ACC_WIDTH] ? '1 : sum_full[ACC_WIDTH-1:0];
`else
    acc_add = sum_full[ACC_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      acc      <= '0;
      acc_done <= 1'b0;
    end else if (s2_valid) begin
      if (s2_start) begin
        acc      <= prod_ext;
        acc_done <= s2_last;
      end else begin
        acc <= acc_add;
        if (s2_last) acc_done <= 1'b1;
      end
    end
  end

  assign bus.c            = acc;
  assign bus.output_valid = acc_done;
endmodule

// File: tb/tb_pe_no_fifo.sv
// Scoreboarded random bench for pe_no_fifo: a per-cycle arithmetic model queues
// expected (c, output_valid) pairs and a negedge monitor compares them.
module tb_pe_no_fifo;
  localparam int DW  = 4;
  localparam int AW  = 16;
  localparam int AW8 = 8;

  typedef struct {
    int          due;
    logic        ov;
    logic [AW-1:0] c;
  } exp_t;

  logic clk;
  logic clr;
  int   cyc;
  int   checks;
  int   errors;
  exp_t q[$];
  exp_t e;
  int   m_acc;
  bit   m_ov;

  pe_no_fifo_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW))  bus  ();
  pe_no_fifo_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW8)) bus8 ();

  pe_no_fifo #(.DATA_WIDTH(DW), .ACC_WIDTH(AW))  dut  (.clk(clk), .clr(clr), .bus(bus));
  pe_no_fifo #(.DATA_WIDTH(DW), .ACC_WIDTH(AW8)) dut8 (.clk(clk), .clr(clr), .bus(bus8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Drives one cycle on the main DUT and queues what c/output_valid must be once it reaches S3.
  task automatic step(input bit v, input bit s, input bit l, input int aa, input int bb);
    int p;
    @(posedge clk);
    #1;
    bus.valid_in = v;
    bus.start    = s;
    bus.last     = l;
    bus.a        = DW'(aa);
    bus.b        = DW'(bb);
    if (v) begin
      p = aa * bb;
      if (s) begin
        m_acc = p;
        m_ov  = l;
      end else begin
        m_acc = m_acc + p;
        if (l) m_ov = 1'b1;
      end
`ifdef PE_SATURATE_EN
      if (m_acc > (1 << AW) - 1) m_acc = (1 << AW) - 1;
`else
      m_acc = m_acc % (1 << AW);
`endif
    end
    q.push_back('{due: cyc + 3, ov: m_ov, c: AW'(m_acc)});
  endtask

  // Invalid cycle with random flags and data, which the DUT must ignore.
  task automatic bubble();
    step(1'b0, 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
  endtask

  task automatic run(input int k, input bit all_max, input bit bubbles);
    for (int i = 0; i < k; i++) begin
      if (bubbles && $urandom_range(0, 1) == 1) bubble();
      if (all_max) step(1'b1, i == 0, i == k - 1, 15, 15);
      else step(1'b1, i == 0, i == k - 1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    clr           = 1'b1;
    bus.valid_in  = 1'b0;
    bus8.valid_in = 1'b0;
    @(posedge clk);
    #1;
    clr   = 1'b0;
    q.delete();
    m_acc = 0;
    m_ov  = 1'b0;
    @(negedge clk);
    check("reset_c", 32'(bus.c), 32'd0);
    check("reset_ov", 32'(bus.output_valid), 32'd0);
    check("reset_c8", 32'(bus8.c), 32'd0);
    check("reset_ov8", 32'(bus8.output_valid), 32'd0);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      check("output_valid", 32'(bus.output_valid), 32'(e.ov));
      check("c", 32'(bus.c), 32'(e.c));
    end
  end

  initial begin
    int sum8;
    checks = 0;
    errors = 0;
    m_acc  = 0;
    m_ov   = 1'b0;
    clr    = 1'b1;
    bus.valid_in = 1'b0; bus.start = 1'b0; bus.last = 1'b0; bus.a = '0; bus.b = '0;
    bus8.valid_in = 1'b0; bus8.start = 1'b0; bus8.last = 1'b0; bus8.a = '0; bus8.b = '0;

    do_reset();

    // Narrow accumulator: 3 x 225 overflows 8 bits.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus8.valid_in = 1'b1;
      bus8.start    = (i == 0);
      bus8.last     = (i == 2);
      bus8.a        = 4'd15;
      bus8.b        = 4'd15;
    end
    @(posedge clk);
    #1;
    bus8.valid_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sum8 = 3 * 15 * 15;
`ifdef PE_SATURATE_EN
    if (sum8 > 255) sum8 = 255;
`else
    sum8 = sum8 % 256;
`endif
    check("overflow_c8", 32'(bus8.c), 32'(sum8));
    check("overflow_ov8", 32'(bus8.output_valid), 32'd1);

    run(16, 1'b1, 1'b0);
    check("model_all_max", 32'(m_acc), 32'h0E10);
    run(16, 1'b0, 1'b0);
    for (int r = 0; r < 10; r++) run(int'($urandom_range(1, 8)), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 7, 9);
    step(1'b1, 1'b1, 1'b1, 7, 9);
    bubble();

    // Bubbled run of 3*3 terms, then a stray term after last.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, i == 3, 3, 3);
      bubble();
      bubble();
    end
    step(1'b1, 1'b0, 1'b0, 2, 2);
    repeat (3) bubble();

    // Reset in the middle of a run discards in-flight terms.
    step(1'b1, 1'b1, 1'b0, 15, 15);
    step(1'b1, 1'b0, 1'b0, 15, 15);
    step(1'b1, 1'b0, 1'b0, 15, 15);
    do_reset();
    repeat (4) bubble();
    for (int r = 0; r < 6; r++) run(int'($urandom_range(1, 12)), 1'b0, 1'b1);
    repeat (5) bubble();

    repeat (8) @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_no_fifo.md
# pe_no_fifo

Unsigned multiply-accumulate processing element for the matrix-multiplier array. It takes one operand pair per cycle, delimited by `start`/`last` framing, and computes the dot product sum(a·b) over one accumulation run (K terms). It flags the finished sum with a valid strobe. There is no input buffering: the upstream feeder must not present data faster than one pair per clock.

## Interface
- DATA_WIDTH, 4 — width of unsigned operands `a`, `b`.
- ACC_WIDTH, DATA_WIDTH**2 — accumulator/output width.
- clk  in  1  — sole clock, rising edge.
- clr  in  1  — synchronous, active-high reset.
- start  in  1  — qualifies the first term of a new accumulation run; meaningful only with `valid_in`.
- valid_in  in  1  — `a`, `b`, `start`, `last` are valid this cycle.
- last  in  1  — qualifies the final term of the run; meaningful only with `valid_in`.
- a  in  DATA_WIDTH  — unsigned multiplicand.
- b  in  DATA_WIDTH  — unsigned multiplier.
- c  out  ACC_WIDTH  — accumulator register contents.
- output_valid  out  1  — `c` holds the completed sum of the current run.

## Operation
- Three registered stages:
  - S1 registers `a`, `b`, `valid_in`, `start`, `last`.
  - S2 registers the product `a*b` (2·DATA_WIDTH bits) and forwards the flags.
  - S3 is the accumulator.
- Product is zero-extended or truncated to ACC_WIDTH. Accumulation wraps modulo 2^ACC_WIDTH.
- S3 behaviour, using the flags as forwarded alongside the product:
  - valid && start: acc <= product. This discards any prior value, including a run in progress.
  - valid && !start: acc <= acc + product.
  - !valid: acc holds. Bubbles are allowed anywhere inside a run.
- output_valid:
  - Set in S3 when a valid term carrying `last` is accumulated.
  - Remains high, with `c` frozen, until the next valid `start` term reaches S3. It clears on that same edge.
- start and last on the same term: single-term run, so c = a*b with output_valid.
- Terms after `last` without a new `start` keep accumulating into `acc`. output_valid stays high. Such traffic is a protocol error, but the behaviour is defined.
- `start`/`last` with valid_in=0 are ignored.
- `c` is driven directly from the accumulator, so intermediate partial sums are visible while output_valid=0.

## Timing
- Reset (clr=1 at an edge) clears all pipeline registers and the accumulator: c=0, output_valid=0. Any in-flight terms are discarded.
- Reset mid-run: the run is lost. The next run must begin with `start`.
- Latency: a term sampled at edge E0 is in acc after edge E0+2.
- output_valid rises after E_last+2, where E_last is the edge that sampled the `last` term.
- At edge E_last+3 and later, c and output_valid are stable until the next run's `start` term reaches S3.
- Throughput: one term per cycle. Back-to-back runs need no gap; the next run's `start` may follow `last` on the very next cycle.
- No ready/backpressure; the input is always accepted.

## Configuration
- PE_SATURATE_EN
  - Defined: accumulation saturates at 2^ACC_WIDTH−1 instead of wrapping. The sticky saturation state is cleared by `start` or reset.
  - Undefined (default): modulo-2^ACC_WIDTH wrap.

## Test plan
- Reset: clr=1 for one edge -> c=0, output_valid=0.
- 16-term run, random 4-bit a/b, start on term 0, last on term 15 -> after 3 edges: output_valid=1 and c = sum(a·b), e.g. all a=b=15 gives c=0x0E10.
- Ten back-to-back runs with no gaps -> each run's sum matches and output_valid re-asserts per run. A stale sum never leaks into the next run.
- Single-term run, a=7, b=9, with start and last together -> c=0x003F, output_valid=1 two edges after sampling.
- Bubbles: 4 terms of a=b=3 with valid_in low between them -> c=0x0024. Flags on invalid cycles are ignored.
- Overflow: ACC_WIDTH=8, 3 terms of 15·15 -> c=0xA3 with wrap; with PE_SATURATE_EN defined, c=0xFF.
